// File: rtl/clock_set_ctrl_if.sv
// Key, time and status signals between the time-setting controller and its neighbours.
// The controller uses the slave modport; whoever drives the keys and time_in uses master.
interface clock_set_ctrl_if;
   logic        key_mode_n;
   logic        key_inc_n;
   logic [23:0] time_in;
   logic [23:0] time_out;
   logic        load;
   logic        setting;
   logic [2:0]  blink_mask;
   logic [1:0]  state_out;

   modport master (
      output key_mode_n, key_inc_n, time_in,
      input  time_out, load, setting, blink_mask, state_out
   );

   modport slave (
      input  key_mode_n, key_inc_n, time_in,
      output time_out, load, setting, blink_mask, state_out
   );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debounced mode/inc keys walk hour/minute/second edit of a shadow time.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat on the increment key.
module clock_set_ctrl #(
   parameter int DB_CYCLES     = 1_000_000,
   parameter int BLINK_CYCLES  = 12_500_000,
   parameter int REPEAT_CYCLES = 15_000_000
) (
   input  logic           clk,
   input  logic           rst,
   clock_set_ctrl_if.slave bus
);
   typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} state_t;

   localparam int DB_W = $clog2(DB_CYCLES + 1);
   localparam int BL_W = $clog2(BLINK_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);
   localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_CYCLES - 1);

   function automatic logic [7:0] wrap_inc(input logic [7:0] value, input logic [7:0] limit);
      return (value >= limit) ? 8'd0 : value + 8'd1;
   endfunction

   logic [1:0]      keys_raw_s;
   logic [1:0]      sync1_r;
   logic [1:0]      sync2_r;
   logic [1:0]      stable_r;
   logic [1:0]      press_r;
   logic [DB_W-1:0] db_cnt_r [2];
   logic            mode_ev_s;
   logic            inc_ev_s;

   state_t          state_r;
   state_t          state_next_s;
   logic [23:0]     time_r;
   logic [23:0]     time_next_s;
   logic            exit_s;
   logic            exit_r;
   logic            load_r;
   logic            setting_r;
   logic [BL_W-1:0] blink_cnt_r;
   logic [BL_W-1:0] blink_cnt_next_s;
   logic            phase_r;
   logic            phase_next_s;
   logic [2:0]      mask_next_s;
   logic [2:0]      blink_mask_r;

   // Index 0 is the mode key, index 1 the increment key; both are active-low.
   assign keys_raw_s = {bus.key_inc_n, bus.key_mode_n};
   assign mode_ev_s  = press_r[0];

   // Synchronizer, debounce counter and released->pressed event pulse for each key
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r  <= 2'b11;
         sync2_r  <= 2'b11;
         stable_r <= 2'b11;
         press_r  <= 2'b00;
         for (int k = 0; k < 2; k++) db_cnt_r[k] <= {DB_W{1'b0}};
      end else begin
         sync1_r <= keys_raw_s;
         sync2_r <= sync1_r;
         for (int k = 0; k < 2; k++) begin
            if (sync2_r[k] == stable_r[k]) begin
               db_cnt_r[k] <= {DB_W{1'b0}};
               press_r[k]  <= 1'b0;
            end else if (db_cnt_r[k] == DB_MAX) begin
               stable_r[k] <= sync2_r[k];
               db_cnt_r[k] <= {DB_W{1'b0}};
               press_r[k]  <= stable_r[k];
            end else begin
               db_cnt_r[k] <= db_cnt_r[k] + DB_W'(1);
               press_r[k]  <= 1'b0;
            end
         end
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RP_W-1:0] RP_MAX = RP_W'(REPEAT_CYCLES - 1);

   logic [RP_W-1:0] rep_cnt_r;
   logic            rep_pulse_r;

   // Hold timer for the debounced inc key; restarts on press, release or any state change
   always_ff @(posedge clk) begin
      if (rst || stable_r[1] || (state_r == RUN) || mode_ev_s || press_r[1]) begin
         rep_cnt_r   <= {RP_W{1'b0}};
         rep_pulse_r <= 1'b0;
      end else if (rep_cnt_r == RP_MAX) begin
         rep_cnt_r   <= {RP_W{1'b0}};
         rep_pulse_r <= 1'b1;
      end else begin
         rep_cnt_r   <= rep_cnt_r + RP_W'(1);
         rep_pulse_r <= 1'b0;
      end
   end

   assign inc_ev_s = press_r[1] | rep_pulse_r;
`else
   assign inc_ev_s = press_r[1];
`endif

   // Next state and shadow-time edit; a mode event always wins over a coincident inc
   always_comb begin
      state_next_s = state_r;
      time_next_s  = time_r;
      exit_s       = 1'b0;
      case (state_r)
         RUN: begin
            if (mode_ev_s) begin
               state_next_s = SET_H;
               time_next_s  = bus.time_in;
            end else begin
               state_next_s = RUN;
            end
         end
         SET_H: begin
            if (mode_ev_s) begin
               state_next_s = SET_M;
            end else if (inc_ev_s) begin
               time_next_s[23:16] = wrap_inc(time_r[23:16], 8'd23);
            end else begin
               state_next_s = SET_H;
            end
         end
         SET_M: begin
            if (mode_ev_s) begin
               state_next_s = SET_S;
            end else if (inc_ev_s) begin
               time_next_s[15:8] = wrap_inc(time_r[15:8], 8'd59);
            end else begin
               state_next_s = SET_M;
            end
         end
         SET_S: begin
            if (mode_ev_s) begin
               state_next_s = RUN;
               exit_s       = 1'b1;
            end else if (inc_ev_s) begin
               time_next_s[7:0] = wrap_inc(time_r[7:0], 8'd59);
            end else begin
               state_next_s = SET_S;
            end
         end
         default: begin
            state_next_s = RUN;
         end
      endcase
   end

   // Blink phase restarts visible on every field entry and every edit
   always_comb begin
      blink_cnt_next_s = blink_cnt_r;
      phase_next_s     = phase_r;
      if ((state_next_s == RUN) || mode_ev_s || inc_ev_s) begin
         blink_cnt_next_s = {BL_W{1'b0}};
         phase_next_s     = 1'b0;
      end else if (blink_cnt_r == BL_MAX) begin
         blink_cnt_next_s = {BL_W{1'b0}};
         phase_next_s     = ~phase_r;
      end else begin
         blink_cnt_next_s = blink_cnt_r + BL_W'(1);
      end
      mask_next_s = {phase_next_s & (state_next_s == SET_H),
                     phase_next_s & (state_next_s == SET_M),
                     phase_next_s & (state_next_s == SET_S)};
   end

   // State register and registered outputs; load trails the return to RUN by one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= RUN;
         time_r       <= 24'd0;
         setting_r    <= 1'b0;
         exit_r       <= 1'b0;
         load_r       <= 1'b0;
         blink_cnt_r  <= {BL_W{1'b0}};
         phase_r      <= 1'b0;
         blink_mask_r <= 3'b000;
      end else begin
         state_r      <= state_next_s;
         time_r       <= time_next_s;
         setting_r    <= (state_next_s != RUN);
         exit_r       <= exit_s;
         load_r       <= exit_r;
         blink_cnt_r  <= blink_cnt_next_s;
         phase_r      <= phase_next_s;
         blink_mask_r <= mask_next_s;
      end
   end

   assign bus.state_out  = state_r;
   assign bus.time_out   = time_r;
   assign bus.setting    = setting_r;
   assign bus.load       = load_r;
   assign bus.blink_mask = blink_mask_r;
endmodule
